regfile_writeback_scheduler: RTL and testbench

//   Write-back stage directly upstream of the 8x16 dual-write register file.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/regfile_writeback_scheduler.sv | 138 +++++++++++++
 tb/tb_regfile_writeback_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path: field widths and the buffered
// write-back entry {addr, data, arrival tag}.
package regfile_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    // Stored tag width; the scheduler's SEQ_W is expected to match it.
    localparam int TAG_W    = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-clock FIFO of write-back entries with a combinational head view.
// With WB_PENDING_QUERY_EN defined it also exposes every slot and its valid bit.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  wb_entry_t            push_entry,
    input  logic                 pop,
    output wb_entry_t            head,
    output logic                 empty,
    output logic [CNT_W-1:0]     count
`ifdef WB_PENDING_QUERY_EN
    ,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]     entry_valid
`endif
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Push and pop together leave the occupancy unchanged.
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

`ifdef WB_PENDING_QUERY_EN
    logic [PTR_W-1:0] offs;

    assign entries = mem_q;

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        entry_valid = '0;
        offs        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs           = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = (CNT_W'(offs) < count_q);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_writeback_scheduler.sv
// Buffers unit A/B results and drives the dual-write register file in arrival order.
// Optional pending-write query port enabled by defining WB_PENDING_QUERY_EN.
module regfile_writeback_scheduler
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SEQ_W = TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              we1,
    output logic [ADDR_W-1:0] write_addr1,
    output logic [DATA_W-1:0] write_data1,
    output logic              we2,
    output logic [ADDR_W-1:0] write_addr2,
    output logic [DATA_W-1:0] write_data2,
    output logic              idle
`ifdef WB_PENDING_QUERY_EN
    ,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              query_pending
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        a_in, b_in, a_head, b_head;
    logic             a_empty, b_empty;
    logic [CNT_W-1:0] a_count, b_count;
    logic             push_a, push_b;
    logic             issue_a, issue_b;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] tag_diff;
    logic             b_older;

    assign a_ready = !rst && (a_count < CNT_W'(DEPTH));
    assign b_ready = !rst && (b_count < CNT_W'(DEPTH));
    assign push_a  = a_valid && a_ready;
    assign push_b  = b_valid && b_ready;
    assign idle    = (a_count == '0) && (b_count == '0);

    always_comb begin
        a_in      = '0;
        a_in.addr = a_addr;
        a_in.data = a_data;
        a_in.tag  = TAG_W'(seq_q);
        b_in      = '0;
        b_in.addr = b_addr;
        b_in.data = b_data;
        b_in.tag  = TAG_W'(seq_q);
        seq_d     = seq_q;
        if (push_a || push_b) begin
            seq_d = seq_q + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    // B is strictly older when (tagA - tagB) mod 2^SEQ_W lies in [1, 2^(SEQ_W-1)).
    assign tag_diff = SEQ_W'(a_head.tag) - SEQ_W'(b_head.tag);
    assign b_older  = (tag_diff != '0) && !tag_diff[SEQ_W-1];

    // Equal-address writes issued together rely on port 2 winning in the file,
    // so A is only held back when B's pending write to that register is older.
    always_comb begin
        issue_b = !b_empty;
        issue_a = !a_empty && !(!b_empty && (a_head.addr == b_head.addr) && b_older);
    end

    assign we1         = issue_a && !rst;
    assign we2         = issue_b && !rst;
    assign write_addr1 = a_head.addr;
    assign write_data1 = a_head.data;
    assign write_addr2 = b_head.addr;
    assign write_data2 = b_head.data;

`ifdef WB_PENDING_QUERY_EN
    wb_entry_t [DEPTH-1:0] a_ents, b_ents;
    logic [DEPTH-1:0]      a_ent_vld, b_ent_vld;

    always_comb begin
        query_pending = 1'b0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a_ent_vld[i] && (a_ents[i].addr == query_addr)) query_pending = 1'b1;
                if (b_ent_vld[i] && (b_ents[i].addr == query_addr)) query_pending = 1'b1;
            end
        end
    end
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk        (clk),
        .rst        (rst),
        .push       (push_a),
        .push_entry (a_in),
        .pop        (we1),
        .head       (a_head),
        .empty      (a_empty),
        .count      (a_count)
`ifdef WB_PENDING_QUERY_EN
        ,
        .entries    (a_ents),
        .entry_valid(a_ent_vld)
`endif
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk        (clk),
        .rst        (rst),
        .push       (push_b),
        .push_entry (b_in),
        .pop        (we2),
        .head       (b_head),
        .empty      (b_empty),
        .count      (b_count)
`ifdef WB_PENDING_QUERY_EN
        ,
        .entries    (b_ents),
        .entry_valid(b_ent_vld)
`endif
    );

endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Scoreboard bench: accepted writes queue per port in arrival order; the monitor checks
// each cycle's write-port activity and the resulting register-file contents.
module tb_regfile_writeback_scheduler;

    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        int          arr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        we1, we2, idle;
    logic [2:0]  write_addr1, write_addr2;
    logic [15:0] write_data1, write_data2;
`ifdef WB_PENDING_QUERY_EN
    logic [2:0]  query_addr;
    logic        query_pending;
`endif

    always #5 clk = ~clk;

    regfile_writeback_scheduler #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .we1        (we1),
        .write_addr1(write_addr1),
        .write_data1(write_data1),
        .we2        (we2),
        .write_addr2(write_addr2),
        .write_data2(write_data2),
        .idle       (idle)
`ifdef WB_PENDING_QUERY_EN
        ,
        .query_addr   (query_addr),
        .query_pending(query_pending)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    ent_t        qa[$];
    ent_t        qb[$];
    logic [15:0] dut_file[8];
    logic [15:0] ref_file[8];
    int          ref_arr[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference register file: the value from the latest-arriving write seen so far.
    task automatic commit(input ent_t e);
        if (e.arr > ref_arr[e.addr]) begin
            ref_arr[e.addr]  = e.arr;
            ref_file[e.addr] = e.data;
        end
    endtask

    function automatic bit pending(input logic [2:0] q);
        foreach (qa[i]) if (qa[i].addr == q) return 1'b1;
        foreach (qb[i]) if (qb[i].addr == q) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin : monitor
        bit   ew1, ew2, pa, pb;
        ent_t e;
        cyc++;
        if (rst) begin
            chk("a_ready_in_rst", a_ready, 0);
            chk("b_ready_in_rst", b_ready, 0);
            chk("we1_in_rst", we1, 0);
            chk("we2_in_rst", we2, 0);
`ifdef WB_PENDING_QUERY_EN
            chk("query_in_rst", query_pending, 0);
`endif
            qa.delete();
            qb.delete();
        end else begin
            ew2 = (qb.size() != 0);
            ew1 = (qa.size() != 0);
            if (ew1 && ew2) begin
                if (qb[0].addr == qa[0].addr && qb[0].arr < qa[0].arr) ew1 = 1'b0;
            end
            pa = a_valid && (qa.size() < DEPTH);
            pb = b_valid && (qb.size() < DEPTH);
            chk("a_ready", a_ready, qa.size() < DEPTH);
            chk("b_ready", b_ready, qb.size() < DEPTH);
            chk("idle", idle, (qa.size() == 0) && (qb.size() == 0));
            chk("we1", we1, ew1);
            chk("we2", we2, ew2);
            if (qa.size() != 0) begin
                chk("addr1", write_addr1, qa[0].addr);
                chk("data1", write_data1, qa[0].data);
            end else begin
                chk("addr1_empty", write_addr1, 0);
                chk("data1_empty", write_data1, 0);
            end
            if (qb.size() != 0) begin
                chk("addr2", write_addr2, qb[0].addr);
                chk("data2", write_data2, qb[0].data);
            end else begin
                chk("addr2_empty", write_addr2, 0);
                chk("data2_empty", write_data2, 0);
            end
`ifdef WB_PENDING_QUERY_EN
            chk("query_pending", query_pending, pending(query_addr));
`endif
            // The file applies port 1 then port 2, so port 2 wins on equal address.
            if (we1) dut_file[write_addr1] = write_data1;
            if (we2) dut_file[write_addr2] = write_data2;
            if (ew1) begin
                e = qa.pop_front();
                commit(e);
            end
            if (ew2) begin
                e = qb.pop_front();
                commit(e);
            end
            if (pa) qa.push_back('{a_addr, a_data, 2 * cyc});
            if (pb) qb.push_back('{b_addr, b_data, 2 * cyc + 1});
        end
    end

    task automatic step(input bit av, input logic [2:0] aa, input logic [15:0] ad,
                        input bit bv, input logic [2:0] ba, input logic [15:0] bd);
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_compare(input string tag);
        int k;
        k       = 0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_drain_timeout"}, (k < 20), 1);
        step(0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("%s_file_r%0d", tag, r), dut_file[r], ref_file[r]);
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin
            dut_file[r] = '0;
            ref_file[r] = '0;
            ref_arr[r]  = -1;
        end
        rst     = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_addr  = 3'd1;
        b_addr  = 3'd2;
        a_data  = 16'h1234;
        b_data  = 16'h5678;
`ifdef WB_PENDING_QUERY_EN
        query_addr = 3'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        chk("idle_after_reset", idle, 1);
        chk("a_ready_after_reset", a_ready, 1);

        // Single A write lands one edge after acceptance.
        step(1, 3'd1, 16'hAAAA, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("single_a_r1", dut_file[1], 16'hAAAA);

        step(1, 3'd2, 16'h1111, 1, 3'd3, 16'h2222);
        step(0, 0, 0, 0, 0, 0);
        chk("pair_r2", dut_file[2], 16'h1111);
        chk("pair_r3", dut_file[3], 16'h2222);

        step(1, 3'd4, 16'hAAAA, 1, 3'd4, 16'hBBBB);
        step(0, 0, 0, 0, 0, 0);
        chk("same_addr_r4", dut_file[4], 16'hBBBB);

        step(0, 0, 0, 1, 3'd5, 16'h0001);
        step(1, 3'd5, 16'h0002, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("order_r5", dut_file[5], 16'h0002);

        // Back-to-back A pushes, with B hitting the same registers.
        for (int i = 0; i < 5; i++) begin
            step(1, 3'(i), 16'hC000 + 16'(i), (i % 2) == 0, 3'(i), 16'hD000 + 16'(i));
        end
        drain_and_compare("burst");

        // Reset with writes buffered: they must be dropped.
        step(1, 3'd7, 16'h7777, 1, 3'd6, 16'h6666);
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("idle_after_mid_reset", idle, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("dropped_r7", dut_file[7], 16'h0000);
        chk("dropped_r6", dut_file[6], 16'h0000);

`ifdef WB_PENDING_QUERY_EN
        step(1, 3'd6, 16'h0606, 0, 0, 0);
        query_addr = 3'd6;
        #1;
        chk("query_hit_r6", query_pending, 1);
        query_addr = 3'd7;
        #1;
        chk("query_miss_r7", query_pending, 0);
        step(0, 0, 0, 0, 0, 0);
`endif

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
`ifdef WB_PENDING_QUERY_EN
            query_addr = 3'($urandom_range(0, 7));
`endif
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(0, 2) != 0, 3'($urandom_range(0, 3)), 16'($urandom));
        end
        rst = 1'b0;
        drain_and_compare("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
